// File: rtl/hpi_access_ctrl_if.sv
// Requester handshake and HPI pin bundle for hpi_access_ctrl.
// slave = the controller; master = requesters plus the HPI device side.
interface hpi_access_ctrl_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [1:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata;
    logic        busy;
    logic        otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n;
    logic [1:0]  otg_hpi_address;
    logic [15:0] otg_hpi_data_out;
    logic        otg_hpi_data_oe;
    logic [15:0] otg_hpi_data_in;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, otg_hpi_data_in,
        output ack0, ack1, rdata, busy, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
               otg_hpi_address, otg_hpi_data_out, otg_hpi_data_oe
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, otg_hpi_data_in,
        input  ack0, ack1, rdata, busy, otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n,
               otg_hpi_address, otg_hpi_data_out, otg_hpi_data_oe
    );
endinterface

// File: rtl/hpi_access_ctrl.sv
// Two-requester round-robin HPI access sequencer: SETUP/STROBE/HOLD/RECOVER
// phases with programmable lengths; every output is registered.
module hpi_access_ctrl #(
    parameter int T_SETUP   = 2,
    parameter int T_STROBE  = 3,
    parameter int T_HOLD    = 1,
    parameter int T_RECOVER = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    hpi_access_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    // Phase counters load length-1 on entry and leave the phase at zero.
    localparam logic [7:0] CNT_SETUP   = 8'(T_SETUP - 1);
    localparam logic [7:0] CNT_STROBE  = 8'(T_STROBE - 1);
    localparam logic [7:0] CNT_HOLD    = 8'(T_HOLD - 1);
    localparam logic [7:0] CNT_RECOVER = 8'(T_RECOVER - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cs_n_q, cs_n_d, r_n_q, r_n_d, w_n_q, w_n_d, oe_q, oe_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic        gnt, gsel, active_d, strobe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        gnt     = 1'b0;
        gsel    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt     = 1'b1;
                    // last_q is the previous winner; on a tie the other side wins.
                    gsel    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    state_d = SETUP;
                    cnt_d   = CNT_SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = STROBE;
                    cnt_d   = CNT_STROBE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_HOLD;
                    if (!we_q) rdata_d = bus.otg_hpi_data_in;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = RECOVER;
                    cnt_d   = CNT_RECOVER;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (gnt) begin
            last_d = gsel;
            we_d   = gsel ? bus.we1 : bus.we0;
            addr_d = gsel ? bus.addr1 : bus.addr0;
            if (we_d) dout_d = gsel ? bus.wdata1 : bus.wdata0;
        end

        // Outputs are derived from the next state so they align with it.
        active_d = state_d inside {SETUP, STROBE, HOLD};
        strobe_d = (state_d == STROBE);
        cs_n_d   = ~active_d;
        r_n_d    = ~(strobe_d & ~we_d);
        w_n_d    = ~(strobe_d & we_d);
        oe_d     = active_d & we_d;
        ack0_d   = (state_d == HOLD) && (cnt_d == 8'd0) && !last_d;
        ack1_d   = (state_d == HOLD) && (cnt_d == 8'd0) && last_d;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 2'd0;
            dout_q  <= 16'd0;
            rdata_q <= 16'd0;
            cs_n_q  <= 1'b1;
            r_n_q   <= 1'b1;
            w_n_q   <= 1'b1;
            oe_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            r_n_q   <= r_n_d;
            w_n_q   <= w_n_d;
            oe_q    <= oe_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack0             = ack0_q;
    assign bus.ack1             = ack1_q;
    assign bus.rdata            = rdata_q;
    assign bus.busy             = busy_q;
    assign bus.otg_hpi_cs_n     = cs_n_q;
    assign bus.otg_hpi_r_n      = r_n_q;
    assign bus.otg_hpi_w_n      = w_n_q;
    assign bus.otg_hpi_address  = addr_q;
    assign bus.otg_hpi_data_out = dout_q;
    assign bus.otg_hpi_data_oe  = oe_q;
endmodule

// File: tb/tb_hpi_access_ctrl.sv
// Bench for hpi_access_ctrl: default-timing and all-ones-timing instances
// checked every cycle against a cycle-offset transaction model.
module tb_hpi_access_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hpi_access_ctrl_if if0();
    hpi_access_ctrl_if if1();

    hpi_access_ctrl dut0 (.clk_clk(clk), .reset_reset_n(rst_n), .bus(if0.slave));
    hpi_access_ctrl #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_RECOVER(1))
        dut1 (.clk_clk(clk), .reset_reset_n(rst_n), .bus(if1.slave));

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    int TS [2] = '{2, 1};
    int TT [2] = '{3, 1};
    int TH [2] = '{1, 1};
    int TR [2] = '{2, 1};

    // Model: mk = cycles since grant (0 = idle), owner, type, latched fields.
    int          mk    [2];
    bit          mlast [2];
    bit          mwe   [2];
    logic [1:0]  maddr [2];
    logic [15:0] mdout [2];
    logic [15:0] mrd   [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset(input int i);
        mk[i] = 0; mlast[i] = 1'b1; mwe[i] = 1'b0;
        maddr[i] = 2'd0; mdout[i] = 16'd0; mrd[i] = 16'd0;
    endtask

    task automatic mstep(input int i, input logic r0, input logic r1, input logic w0, input logic w1,
                         input logic [1:0] a0, input logic [1:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] din);
        int tot;
        bit g;
        tot = TS[i] + TT[i] + TH[i] + TR[i];
        if (mk[i] != 0) begin
            if (mk[i] == TS[i] + TT[i] && !mwe[i]) mrd[i] = din;
            mk[i] = (mk[i] == tot) ? 0 : mk[i] + 1;
        end else if (r0 || r1) begin
            g = (r0 && r1) ? !mlast[i] : r1;
            mlast[i] = g;
            mwe[i]   = g ? w1 : w0;
            maddr[i] = g ? a1 : a0;
            if (mwe[i]) mdout[i] = g ? d1 : d0;
            mk[i] = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, if0.req0, if0.req1, if0.we0, if0.we1, if0.addr0, if0.addr1,
                  if0.wdata0, if0.wdata1, if0.otg_hpi_data_in);
            mstep(1, if1.req0, if1.req1, if1.we0, if1.we1, if1.addr0, if1.addr1,
                  if1.wdata0, if1.wdata1, if1.otg_hpi_data_in);
        end
    end

    task automatic cmp(input int i, input logic cs_n, input logic r_n, input logic w_n, input logic oe,
                       input logic a0, input logic a1, input logic busy, input logic [1:0] addr,
                       input logic [15:0] dout, input logic [15:0] rd);
        int  k, aend;
        bit  act, stb;
        k    = mk[i];
        aend = TS[i] + TT[i] + TH[i];
        act  = (k >= 1) && (k <= aend);
        stb  = (k > TS[i]) && (k <= TS[i] + TT[i]);
        chk($sformatf("cs_n%0d", i), cs_n, !act);
        chk($sformatf("r_n%0d", i), r_n, !(stb && !mwe[i]));
        chk($sformatf("w_n%0d", i), w_n, !(stb && mwe[i]));
        chk($sformatf("oe%0d", i), oe, act && mwe[i]);
        chk($sformatf("ack0_%0d", i), a0, (k == aend) && !mlast[i]);
        chk($sformatf("ack1_%0d", i), a1, (k == aend) && mlast[i]);
        chk($sformatf("busy%0d", i), busy, k != 0);
        chk($sformatf("addr%0d", i), addr, maddr[i]);
        chk($sformatf("dout%0d", i), dout, mdout[i]);
        chk($sformatf("rdata%0d", i), rd, mrd[i]);
        chk($sformatf("rw_excl%0d", i), !r_n && !w_n, 0);
        chk($sformatf("strobe_cs%0d", i), (!r_n || !w_n) && cs_n, 0);
        chk($sformatf("ack_excl%0d", i), a0 && a1, 0);
    endtask

    always @(negedge clk) begin
        if (run) begin
            cmp(0, if0.otg_hpi_cs_n, if0.otg_hpi_r_n, if0.otg_hpi_w_n, if0.otg_hpi_data_oe,
                if0.ack0, if0.ack1, if0.busy, if0.otg_hpi_address, if0.otg_hpi_data_out, if0.rdata);
            cmp(1, if1.otg_hpi_cs_n, if1.otg_hpi_r_n, if1.otg_hpi_w_n, if1.otg_hpi_data_oe,
                if1.ack0, if1.ack1, if1.busy, if1.otg_hpi_address, if1.otg_hpi_data_out, if1.rdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int who[$];
        int when[$];
        int n_ack1;
        {if0.req0, if0.req1, if0.we0, if0.we1} = '0;
        {if1.req0, if1.req1, if1.we0, if1.we1} = '0;
        if0.addr0 = 0; if0.addr1 = 0; if0.wdata0 = 0; if0.wdata1 = 0; if0.otg_hpi_data_in = 0;
        if1.addr0 = 0; if1.addr1 = 0; if1.wdata0 = 0; if1.wdata1 = 0; if1.otg_hpi_data_in = 0;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", if0.otg_hpi_cs_n, 1);
        chk("rst_busy", if0.busy, 0);
        chk("rst_rdata", if0.rdata, 0);
        chk("rst_ack0", if0.ack0, 0);
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);

        // Write, default timing: cycle 0 is this idle cycle.
        if0.req0 = 1; if0.we0 = 1; if0.addr0 = 2; if0.wdata0 = 16'h1234;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            case (c)
                1: begin
                    chk("wr_cs_c1", if0.otg_hpi_cs_n, 0);
                    chk("wr_dout_c1", if0.otg_hpi_data_out, 16'h1234);
                    chk("wr_oe_c1", if0.otg_hpi_data_oe, 1);
                    chk("wr_addr_c1", if0.otg_hpi_address, 2);
                end
                2: chk("wr_wn_c2", if0.otg_hpi_w_n, 1);
                3: chk("wr_wn_c3", if0.otg_hpi_w_n, 0);
                5: begin chk("wr_wn_c5", if0.otg_hpi_w_n, 0); chk("wr_ack_c5", if0.ack0, 0); end
                6: begin
                    chk("wr_ack_c6", if0.ack0, 1);
                    chk("wr_wn_c6", if0.otg_hpi_w_n, 1);
                    chk("wr_cs_c6", if0.otg_hpi_cs_n, 0);
                    if0.req0 = 0;
                end
                7: begin chk("wr_cs_c7", if0.otg_hpi_cs_n, 1); chk("wr_oe_c7", if0.otg_hpi_data_oe, 0); end
                8: chk("wr_busy_c8", if0.busy, 1);
                9: chk("wr_busy_c9", if0.busy, 0);
                default: ;
            endcase
        end

        // Read by requester 1.
        if0.req1 = 1; if0.we1 = 0; if0.addr1 = 0; if0.otg_hpi_data_in = 16'h0000;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            case (c)
                1: chk("rd_oe_c1", if0.otg_hpi_data_oe, 0);
                2: if0.otg_hpi_data_in = 16'hBEEF;
                3: begin chk("rd_rn_c3", if0.otg_hpi_r_n, 0); chk("rd_wn_c3", if0.otg_hpi_w_n, 1); end
                5: begin chk("rd_rn_c5", if0.otg_hpi_r_n, 0); chk("rd_rdata_c5", if0.rdata, 0); end
                6: begin
                    chk("rd_rn_c6", if0.otg_hpi_r_n, 1);
                    chk("rd_rdata_c6", if0.rdata, 16'hBEEF);
                    chk("rd_ack1_c6", if0.ack1, 1);
                    chk("rd_oe_c6", if0.otg_hpi_data_oe, 0);
                    if0.req1 = 0; if0.otg_hpi_data_in = 16'h1111;
                end
                8: chk("rd_rdata_c8", if0.rdata, 16'hBEEF);
                9: chk("rd_busy_c9", if0.busy, 0);
                default: ;
            endcase
        end

        // Contention: both held high, grants alternate starting with 0.
        if0.req0 = 1; if0.we0 = 1; if0.addr0 = 1; if0.wdata0 = 16'hA5A5;
        if0.req1 = 1; if0.we1 = 0; if0.addr1 = 3; if0.otg_hpi_data_in = 16'h5A5A;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (if0.ack0) begin who.push_back(0); when.push_back(c); end
            if (if0.ack1) begin who.push_back(1); when.push_back(c); end
            if (c == 36) begin if0.req0 = 0; if0.req1 = 0; end
        end
        chk("cont_nacks", who.size(), 4);
        if (who.size() == 4) begin
            chk("cont_who0", who[0], 0); chk("cont_who1", who[1], 1);
            chk("cont_who2", who[2], 0); chk("cont_who3", who[3], 1);
            chk("cont_when0", when[0], 6);  chk("cont_when1", when[1], 15);
            chk("cont_when2", when[2], 24); chk("cont_when3", when[3], 33);
        end

        // Requests during busy wait; a drop before grant is ignored, after grant is not.
        if0.req0 = 1; if0.we0 = 1; if0.addr0 = 3; if0.wdata0 = 16'h0F0F;
        n_ack1 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (if0.ack1) n_ack1++;
            case (c)
                2: begin if0.req1 = 1; if0.we1 = 1; if0.addr1 = 2; if0.wdata1 = 16'h7777; end
                4: if0.req1 = 0;
                5: if0.req1 = 1;
                6: if0.req0 = 0;
                10: chk("wait_dout_c10", if0.otg_hpi_data_out, 16'h7777);
                11: if0.req1 = 0;
                15: chk("wait_ack1_c15", if0.ack1, 1);
                default: ;
            endcase
        end
        chk("wait_nack1", n_ack1, 1);

        // Reset during STROBE of a write; pending req0 restarts after release.
        if0.req0 = 1; if0.we0 = 1; if0.addr0 = 2; if0.wdata0 = 16'hCAFE;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wn", if0.otg_hpi_w_n, 1);
        chk("rst_mid_cs", if0.otg_hpi_cs_n, 1);
        chk("rst_mid_busy", if0.busy, 0);
        chk("rst_mid_oe", if0.otg_hpi_data_oe, 0);
        chk("rst_mid_dout", if0.otg_hpi_data_out, 0);
        chk("rst_mid_rdata", if0.rdata, 0);
        chk("rst_mid_ack", if0.ack0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            case (c)
                1: begin
                    chk("rst_re_cs_c1", if0.otg_hpi_cs_n, 0);
                    chk("rst_re_wn_c1", if0.otg_hpi_w_n, 1);
                    chk("rst_re_dout_c1", if0.otg_hpi_data_out, 16'hCAFE);
                end
                3: chk("rst_re_wn_c3", if0.otg_hpi_w_n, 0);
                6: begin chk("rst_re_ack_c6", if0.ack0, 1); if0.req0 = 0; end
                default: ;
            endcase
        end

        // All-ones timing: ack at 3, next grant at 5, one-cycle strobe.
        if1.req0 = 1; if1.we0 = 1; if1.addr0 = 1; if1.wdata0 = 16'h00FF;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            case (c)
                1: begin chk("p1_wn_c1", if1.otg_hpi_w_n, 1); chk("p1_cs_c1", if1.otg_hpi_cs_n, 0); end
                2: chk("p1_wn_c2", if1.otg_hpi_w_n, 0);
                3: begin chk("p1_wn_c3", if1.otg_hpi_w_n, 1); chk("p1_ack_c3", if1.ack0, 1); end
                4: begin chk("p1_busy_c4", if1.busy, 1); chk("p1_cs_c4", if1.otg_hpi_cs_n, 1); end
                5: chk("p1_busy_c5", if1.busy, 0);
                7: begin chk("p1_wn_c7", if1.otg_hpi_w_n, 0); chk("p1_ack_c7", if1.ack0, 0); end
                8: begin chk("p1_ack_c8", if1.ack0, 1); if1.req0 = 0; end
                10: begin if1.req1 = 1; if1.we1 = 0; if1.addr1 = 3; if1.otg_hpi_data_in = 16'h1357; end
                12: chk("p1_rn_c12", if1.otg_hpi_r_n, 0);
                13: begin
                    chk("p1_rdata_c13", if1.rdata, 16'h1357);
                    chk("p1_ack1_c13", if1.ack1, 1);
                    if1.req1 = 0;
                end
                default: ;
            endcase
        end

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
